// File: rtl/lsu_mem_access.sv
// lsu_mem_access: RV32I load/store unit with req/ack bus, misalignment and timeout detection
module lsu_mem_access #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [6:0]  operation,
   input  logic [2:0]  funct3,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_store,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] data_mem,
   output logic        busy,
   output logic        done,
   output logic        misalign,
   output logic        bus_err
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   state_t state, nxt;
   logic [31:0] cnt;
   logic [2:0] f3;
   logic [1:0] off;
   logic [31:0] sh, ld_val;
   logic is_ld, is_st, acc, legal, bad, tmo, fin;
   assign is_ld = operation == 7'b0000011;
   assign is_st = operation == 7'b0100011;
   assign acc = req_valid && (is_ld || is_st) && state == IDLE;
   assign legal = is_ld ? funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}
                        : funct3 inside {3'b000, 3'b001, 3'b010};
   assign bad = !legal || (funct3[1:0] == 2'b01 && data_addr[0])
                       || (funct3[1:0] == 2'b10 && data_addr[1:0] != 2'b00);
   assign tmo = TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1);
   assign fin = state == REQ && (mem_ack || tmo);
   assign sh = mem_rdata >> {off, 3'b000};
   assign ld_val = f3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                   f3 == 3'b100 ? {24'h0, sh[7:0]} :
                   f3 == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
                   f3 == 3'b101 ? {16'h0, sh[15:0]} : mem_rdata;
   // state register
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= nxt;
   // next state and state-decoded outputs; ack ranks above timeout so a final-cycle ack completes normally
   always_comb begin
      mem_req = state == REQ;
      done    = state == DONE;
      busy    = state == REQ || (state == IDLE && req_valid && (is_ld || is_st));
      nxt     = state == IDLE ? (acc ? (bad ? DONE : REQ) : IDLE) :
                state == REQ  ? (fin ? DONE : REQ) : IDLE;
   end
   // bus request capture on accept, result capture on completion
   always_ff @(posedge clk)
      if (rst) begin
         cnt       <= '0;
         f3        <= '0;
         off       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wstrb <= '0;
         mem_wdata <= '0;
         data_mem  <= '0;
         misalign  <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         cnt <= state == REQ ? cnt + 32'd1 : '0;
         if (acc) begin
            f3        <= funct3;
            off       <= data_addr[1:0];
            mem_we    <= is_st;
            mem_addr  <= {data_addr[31:2], 2'b00};
            mem_wstrb <= !is_st ? 4'h0 :
                         funct3[1:0] == 2'b00 ? 4'b0001 << data_addr[1:0] :
                         funct3[1:0] == 2'b01 ? 4'b0011 << data_addr[1:0] : 4'hF;
            mem_wdata <= funct3[1:0] == 2'b00 ? {4{data_store[7:0]}} :
                         funct3[1:0] == 2'b01 ? {2{data_store[15:0]}} : data_store;
            data_mem  <= '0;
            misalign  <= bad;
            bus_err   <= 1'b0;
         end else if (fin) begin
            data_mem <= mem_ack && !mem_we ? ld_val : '0;
            bus_err  <= !mem_ack;
         end
      end
endmodule

// File: tb/tb_lsu_mem_access.sv
// tb_lsu_mem_access: vector table plus scoreboard bench for the load/store unit
module tb_lsu_mem_access;
   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;
   logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, mem_ack = 1'b0;
   logic [6:0] operation = '0;
   logic [2:0] funct3 = '0;
   logic [31:0] data_addr = '0, data_store = '0, mem_rdata = '0;
   logic mem_req, mem_we, busy, done, misalign, bus_err;
   logic [31:0] mem_addr, mem_wdata, data_mem;
   logic [3:0] mem_wstrb;
   typedef struct {
      logic [6:0] op; logic [2:0] f3; logic [31:0] addr, store, rdata; int waits;
      logic [31:0] e_addr; logic e_we; logic [3:0] e_strb; logic [31:0] e_wdata, e_data;
      logic e_mis, e_err; int e_lat;
   } vec_t;
   typedef struct { logic [31:0] data; logic mis, err; } exp_t;
   exp_t sb[$];
   vec_t tbl[14];
   int n_chk = 0, n_fail = 0;
   lsu_mem_access #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .operation(operation), .funct3(funct3),
      .data_addr(data_addr), .data_store(data_store), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .data_mem(data_mem), .busy(busy), .done(done),
      .misalign(misalign), .bus_err(bus_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // scoreboard: every done pulse is matched against the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) chk("unexpected done", done, 0);
         else begin
            e = sb.pop_front();
            chk("data_mem", data_mem, e.data);
            chk("misalign", misalign, e.mis);
            chk("bus_err", bus_err, e.err);
            chk("busy in done", busy, 0);
         end
      end
   end
   task automatic run(input vec_t v);
      int got = -1, reqs = 0;
      exp_t e;
      req_valid = 1'b1; operation = v.op; funct3 = v.f3; data_addr = v.addr; data_store = v.store;
      e.data = v.e_data; e.mis = v.e_mis; e.err = v.e_err;
      sb.push_back(e);
      @(negedge clk);
      chk("busy on request", busy, 1);
      @(posedge clk); #1;
      req_valid = 1'b0; operation = '0;
      for (int c = 1; c <= 20 && got < 0; c++) begin
         mem_ack = c == v.waits + 1;
         mem_rdata = v.rdata;
         @(negedge clk);
         if (mem_req) reqs++;
         if (c == 1 && !v.e_mis) begin
            chk("mem_addr", mem_addr, v.e_addr);
            chk("mem_we", mem_we, v.e_we);
            chk("mem_wstrb", mem_wstrb, v.e_strb);
            if (v.e_we) chk("mem_wdata", mem_wdata, v.e_wdata);
         end
         if (done) got = c;
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
      chk("done cycle", got, v.e_lat);
      chk("mem_req cycles", reqs, v.e_mis ? 0 : v.e_lat - 1);
   endtask
   initial begin
      tbl[0]  = '{LD, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 32'h100, 1'b0, 4'h0, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 2};
      tbl[1]  = '{LD, 3'b101, 32'h202, 32'h0, 32'hBEEF0000, 3, 32'h200, 1'b0, 4'h0, 32'h0, 32'h0000BEEF, 1'b0, 1'b0, 5};
      tbl[2]  = '{ST, 3'b000, 32'h7, 32'h123456AB, 32'h0, 1, 32'h4, 1'b1, 4'b1000, 32'hABABABAB, 32'h0, 1'b0, 1'b0, 3};
      tbl[3]  = '{ST, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 0, 32'h8, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 2};
      tbl[4]  = '{LD, 3'b010, 32'h102, 32'h0, 32'h0, 0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1};
      tbl[5]  = '{ST, 3'b001, 32'h1, 32'h5555, 32'h0, 0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1};
      tbl[6]  = '{LD, 3'b001, 32'h106, 32'h0, 32'h80017FFF, 0, 32'h104, 1'b0, 4'h0, 32'h0, 32'hFFFF8001, 1'b0, 1'b0, 2};
      tbl[7]  = '{LD, 3'b100, 32'h101, 32'h0, 32'h0000F000, 0, 32'h100, 1'b0, 4'h0, 32'h0, 32'h000000F0, 1'b0, 1'b0, 2};
      tbl[8]  = '{LD, 3'b010, 32'h10C, 32'h0, 32'h12345678, 2, 32'h10C, 1'b0, 4'h0, 32'h0, 32'h12345678, 1'b0, 1'b0, 4};
      tbl[9]  = '{ST, 3'b001, 32'h12, 32'hAAAA5566, 32'h0, 0, 32'h10, 1'b1, 4'b1100, 32'h55665566, 32'h0, 1'b0, 1'b0, 2};
      tbl[10] = '{LD, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 99, 32'h20, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 5};
      tbl[11] = '{LD, 3'b011, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1};
      tbl[12] = '{ST, 3'b100, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1};
      tbl[13] = '{LD, 3'b000, 32'h100, 32'h0, 32'h0000007F, 0, 32'h100, 1'b0, 4'h0, 32'h0, 32'h0000007F, 1'b0, 1'b0, 2};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset mem_req", mem_req, 0);
      chk("reset mem_we", mem_we, 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset mem_wstrb", mem_wstrb, 0);
      chk("reset mem_wdata", mem_wdata, 0);
      chk("reset data_mem", data_mem, 0);
      chk("reset done", done, 0);
      chk("reset misalign", misalign, 0);
      chk("reset bus_err", bus_err, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = 1'b1; operation = 7'b0110011;
      @(negedge clk);
      chk("busy non-lsu op", busy, 0);
      @(posedge clk); #1;
      req_valid = 1'b0; operation = '0;
      @(negedge clk);
      chk("non-lsu op mem_req", mem_req, 0);
      chk("non-lsu op done", done, 0);
      @(posedge clk); #1;
      foreach (tbl[i]) run(tbl[i]);
      req_valid = 1'b1; operation = LD; funct3 = 3'b010; data_addr = 32'h40;
      @(posedge clk); #1;
      req_valid = 1'b0; operation = '0;
      @(negedge clk);
      chk("mid-op mem_req", mem_req, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      chk("post-reset mem_req", mem_req, 0);
      chk("post-reset done", done, 0);
      chk("post-reset mem_addr", mem_addr, 0);
      chk("post-reset data_mem", data_mem, 0);
      chk("post-reset busy", busy, 0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      chk("late ack done", done, 0);
      chk("late ack mem_req", mem_req, 0);
      chk("late ack data_mem", data_mem, 0);
      chk("late ack bus_err", bus_err, 0);
      chk("scoreboard drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
